elbeth_pipe_skid_reg: RTL and testbench

Parametrised, handshaked pipeline-stage register for the ELBETH core. It is the next generation of the fixed-field stage registers (IF/ID, ID/EXS, EXS/MEM, MEM/WB).
- Carries an opaque payload of PAYLOAD_W bits using valid/ready handshakes on both sides.
- A two-entry skid buffer gives full throughput with a registered in_ready.
- Keeps the hazard unit's ctrl_stall/ctrl_flush interface.
- Flush clears only the low CTRL_W control bits of the payload, so squashed instructions become architectural bubbles.

---
 rtl/elbeth_pipe_pkg.sv | 37 +++
 rtl/elbeth_sat_counter.sv | 19 +
 rtl/elbeth_pipe_skid_reg.sv | 110 +++++++++++
 tb/tb_elbeth_pipe_skid_reg.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/elbeth_pipe_pkg.sv
// rtl/elbeth_pipe_pkg.sv - shared state encoding, stage widths and control-field offsets
// Optional perf counters in the stage register are enabled with ELBETH_PIPE_PERF_EN.
package elbeth_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int DEFAULT_PAYLOAD_W = 160;
  localparam int DEFAULT_CTRL_W    = 16;
  localparam int DEFAULT_CNT_W     = 32;

  // Per-stage payload geometry; control bits always sit in the LSBs.
  localparam int IF_ID_PAYLOAD_W   = 96;
  localparam int IF_ID_CTRL_W      = 8;
  localparam int ID_EXS_PAYLOAD_W  = 160;
  localparam int ID_EXS_CTRL_W     = 16;
  localparam int EXS_MEM_PAYLOAD_W = 128;
  localparam int EXS_MEM_CTRL_W    = 16;
  localparam int MEM_WB_PAYLOAD_W  = 80;
  localparam int MEM_WB_CTRL_W     = 8;

  localparam int CTRL_REG_W_BIT     = 0;
  localparam int CTRL_MEM_EN_BIT    = 1;
  localparam int CTRL_MEM_RW_BIT    = 2;
  localparam int CTRL_EXCEPTION_BIT = 3;
  localparam int CTRL_ERET_BIT      = 4;
  localparam int CTRL_CSR_CMD_LSB   = 5;
  localparam int CTRL_CSR_CMD_W     = 3;

  function automatic logic [2:0] csr_cmd_of(input logic [DEFAULT_CTRL_W-1:0] ctrl);
    return ctrl[CTRL_CSR_CMD_LSB +: CTRL_CSR_CMD_W];
  endfunction

endpackage

// File: rtl/elbeth_sat_counter.sv
// rtl/elbeth_sat_counter.sv - saturating up-counter with synchronous clear
module elbeth_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/elbeth_pipe_skid_reg.sv
// rtl/elbeth_pipe_skid_reg.sv - handshaked pipeline stage register with two-entry skid buffer
// Perf counters (perf_stall_cnt, perf_flush_cnt) exist only with ELBETH_PIPE_PERF_EN.
module elbeth_pipe_skid_reg
  import elbeth_pipe_pkg::*;
#(
  parameter int PAYLOAD_W = DEFAULT_PAYLOAD_W,
  parameter int CTRL_W    = DEFAULT_CTRL_W
`ifdef ELBETH_PIPE_PERF_EN
  ,
  parameter int CNT_W     = DEFAULT_CNT_W
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ctrl_stall,
  input  logic                 ctrl_flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
`ifdef ELBETH_PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]     perf_stall_cnt,
  output logic [CNT_W-1:0]     perf_flush_cnt
`endif
);

  state_t               state_q;
  logic [PAYLOAD_W-1:0] main_q;
  logic [PAYLOAD_W-1:0] skid_q;
  logic                 in_ready_q;
  logic                 main_v;
  logic                 skid_v;
  logic                 fire_in;
  logic                 fire_out;

  assign main_v    = (state_q == ONE) || (state_q == FULL);
  assign skid_v    = (state_q == FULL);
  assign out_valid = main_v;
  assign out_data  = main_q;
  // in_ready is its own flop, kept equal to ~skid_v, so out_ready never reaches it.
  assign in_ready  = in_ready_q;
  assign fire_out  = main_v & out_ready & ~ctrl_stall;
  assign fire_in   = in_valid & in_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else if (ctrl_flush) begin
      // Squash: control bits become a bubble, data bits are left untouched.
      state_q                <= EMPTY;
      main_q[CTRL_W-1:0]     <= '0;
      skid_q[CTRL_W-1:0]     <= '0;
      in_ready_q             <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (fire_in) begin
            main_q  <= in_data;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (fire_in && fire_out) begin
            main_q <= in_data;
          end else if (fire_out) begin
            state_q <= EMPTY;
          end else if (fire_in) begin
            skid_q     <= in_data;
            state_q    <= FULL;
            in_ready_q <= 1'b0;
          end
        end
        FULL: begin
          if (fire_out) begin
            main_q     <= skid_q;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef ELBETH_PIPE_PERF_EN
  elbeth_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (main_v & ~fire_out & ~ctrl_flush),
    .cnt (perf_stall_cnt)
  );

  elbeth_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (ctrl_flush & (main_v | skid_v)),
    .cnt (perf_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_elbeth_pipe_skid_reg.sv
// tb/tb_elbeth_pipe_skid_reg.sv - scoreboard bench for elbeth_pipe_skid_reg (optionally ELBETH_PIPE_PERF_EN)
module tb_elbeth_pipe_skid_reg;

  localparam int PW = 160;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ctrl_stall;
  logic          ctrl_flush;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_data;
`ifdef ELBETH_PIPE_PERF_EN
  logic [31:0]   perf_stall_cnt;
  logic [31:0]   perf_flush_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [PW-1:0] sb[$];

  always #5 clk = ~clk;

  elbeth_pipe_skid_reg #(.PAYLOAD_W(PW), .CTRL_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_stall (ctrl_stall),
    .ctrl_flush (ctrl_flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef ELBETH_PIPE_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: update the scoreboard from the handshake about to be taken, then check the new state.
  task automatic step();
    bit fi, fo;
    fi = in_valid && in_ready;
    fo = out_valid && out_ready && !ctrl_stall;
    if (rst || ctrl_flush) begin
      sb.delete();
    end else begin
      if (fo && sb.size() != 0) void'(sb.pop_front());
      if (fi) sb.push_back(in_data);
    end
    @(posedge clk);
    #1;
    chk("held_le_2", PW'(sb.size() <= 2), PW'(1));
    chk("in_ready", PW'(in_ready), PW'(sb.size() < 2));
    chk("out_valid", PW'(out_valid), PW'(sb.size() != 0));
    if (sb.size() != 0) chk("out_data", out_data, sb[0]);
  endtask

  task automatic send(input logic [PW-1:0] d);
    bit took;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20; i++) begin
      took = in_ready;
      step();
      if (took) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("send_timeout", PW'(1), PW'(0));
  endtask

  task automatic drain();
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    ctrl_stall = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    chk("drained", PW'(sb.size()), PW'(0));
  endtask

  task automatic comb_probe();
    logic r;
    r = in_ready;
    out_ready = ~out_ready;
    #1;
    chk("in_ready_comb", PW'(in_ready), PW'(r));
    out_ready = ~out_ready;
    #1;
  endtask

  initial begin
    logic [PW-1:0] ff;
`ifdef ELBETH_PIPE_PERF_EN
    logic [31:0] base;
`endif
    rst = 1'b1; ctrl_stall = 1'b0; ctrl_flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_out_data", out_data, '0);
`ifdef ELBETH_PIPE_PERF_EN
    chk("rst_perf_stall", PW'(perf_stall_cnt), '0);
    chk("rst_perf_flush", PW'(perf_flush_cnt), '0);
`endif

    // Full-rate stream.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(PW'(i));
    drain();

    // Back-pressure fills main and skid, third beat waits upstream.
    out_ready = 1'b0;
    send(PW'('hA));
    send(PW'('hB));
    in_valid = 1'b1; in_data = PW'('hC);
    step(); step();
    chk("bp_in_ready", PW'(in_ready), PW'(0));
    chk("bp_main", out_data, PW'('hA));
    out_ready = 1'b1;
    send(PW'('hC));
    drain();

    // Stall with a valid beat and a willing consumer.
    ctrl_stall = 1'b1;
    out_ready  = 1'b1;
    send(PW'('h55));
`ifdef ELBETH_PIPE_PERF_EN
    base = perf_stall_cnt;
`endif
    step(); step(); step();
    chk("stall_stable", out_data, PW'('h55));
`ifdef ELBETH_PIPE_PERF_EN
    chk("perf_stall_3", PW'(perf_stall_cnt - base), PW'(3));
`endif
    drain();

    // Flush from FULL with a concurrent incoming beat.
    out_ready = 1'b0;
    ff = PW'(32'hFFFF_FFFF);
    send(ff);
    send(ff);
`ifdef ELBETH_PIPE_PERF_EN
    base = perf_flush_cnt;
`endif
    in_valid = 1'b1; in_data = PW'('h1234); ctrl_flush = 1'b1;
    step();
    ctrl_flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", PW'(out_valid), PW'(0));
    chk("flush_in_ready", PW'(in_ready), PW'(1));
    chk("flush_main_q", out_data, PW'(32'hFFFF_0000));
`ifdef ELBETH_PIPE_PERF_EN
    chk("perf_flush_1", PW'(perf_flush_cnt - base), PW'(1));
`endif
    out_ready = 1'b1;
    step(); step();

    // Reset together with flush in ONE, then a normal beat.
    out_ready = 1'b0;
    send(PW'('h99));
    rst = 1'b1; ctrl_flush = 1'b1;
    step();
    rst = 1'b0; ctrl_flush = 1'b0;
    chk("rst2_out_data", out_data, '0);
`ifdef ELBETH_PIPE_PERF_EN
    chk("rst2_perf_stall", PW'(perf_stall_cnt), '0);
    chk("rst2_perf_flush", PW'(perf_flush_cnt), '0);
`endif
    out_ready = 1'b1;
    send(PW'('h77));
    drain();

    // Random traffic against the scoreboard.
    for (int c = 0; c < 10000; c++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_data    = {$urandom, $urandom, $urandom, $urandom, $urandom};
      out_ready  = 1'($urandom_range(0, 1));
      ctrl_stall = ($urandom_range(0, 3) == 0);
      if (c % 97 == 0) comb_probe();
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
